// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: datapath width and the writeback result-select encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RESULT_ALU = 2'b00,
    RESULT_MEM = 2'b01,
    RESULT_PC4 = 2'b10
  } result_src_e;

endpackage

// File: rtl/dmem.sv
// Word-organised data memory: synchronous write, asynchronous read, no reset on contents.
module dmem
  import riscv_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read is combinational, so a same-cycle store is observed only after the edge.
  assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// MEM stage plus MEM/WB pipeline register and writeback mux.
// Optional misaligned-access detection is enabled with `define DMEM_MISALIGN_CHECK_EN.
module memory_stage
  import riscv_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [4:0]      RdM,
  input  logic            MemWriteM,
  input  logic            RegWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic            StallW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [4:0]      RdW,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [XLEN-1:0] ResultW,
  output logic            MisalignW
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_rdata;
  logic            misalign_m;
  logic            mem_we;
  logic            unused_addr_bits;

  assign mem_addr = ALUResultM[AW+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign_m = (ALUResultM[1:0] != 2'b00) &&
                      (MemWriteM || (ResultSrcM == RESULT_MEM));
  assign unused_addr_bits = ^ALUResultM[XLEN-1:AW+2];
`else
  assign misalign_m = 1'b0;
  assign unused_addr_bits = ^{ALUResultM[XLEN-1:AW+2], ALUResultM[1:0]};
`endif

  // Gating on reset drops a store whose edge lands while reset is held low.
  assign mem_we = MemWriteM && !StallW && reset && !misalign_m;

  dmem #(.DEPTH(DEPTH)) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (WriteDataM),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      MisalignW  <= 1'b0;
    end else if (!StallW) begin
      ALUResultW <= ALUResultM;
      ReadDataW  <= mem_rdata;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
      RegWriteW  <= RegWriteM && !misalign_m;
      ResultSrcW <= ResultSrcM;
      MisalignW  <= misalign_m;
    end
  end

  always_comb begin
    ResultW = ALUResultW;
    case (ResultSrcW)
      RESULT_MEM: ResultW = ReadDataW;
      RESULT_PC4: ResultW = PCPlus4W;
      default:    ResultW = ALUResultW;
    endcase
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 64, data-memory size in 32-bit words (power of two).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports ALUResultM, WriteDataM, PCPlus4M  input  32 each  byte address / ALU result, store data, PC+4 from execute.
REQ-005 SHALL have ports RdM  input  5, MemWriteM  input  1, RegWriteM  input  1, ResultSrcM  input  2  control from execute.
REQ-006 SHALL have port StallW  input  1  hold MEM/WB register and block store.
REQ-007 SHALL have ports ALUResultW, ReadDataW, PCPlus4W  output  32 each  registered MEM/WB values.
REQ-008 SHALL have ports RdW  output  5, RegWriteW  output  1, ResultSrcW  output  2  registered control.
REQ-009 SHALL have port ResultW  output  32  writeback mux result.
REQ-010 SHALL have port MisalignW  output  1  registered misaligned-access flag.

Function
REQ-011 SHALL word-address memory with ALUResultM[log2(DEPTH)+1:2]; higher bits ignored (wrap modulo DEPTH).
REQ-012 SHALL write WriteDataM to addressed word at rising clk when MemWriteM=1 and StallW=0.
REQ-013 SHALL read memory combinationally and capture it into ReadDataW at the same edge as other MEM/WB fields; latency one cycle M->W.
REQ-014 SHALL, on store and load to same word in same cycle, return pre-write (old) data in ReadDataW.
REQ-015 SHALL, when StallW=0, load ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, MisalignW from M-stage values at each rising clk.
REQ-016 SHALL, when StallW=1, hold all MEM/WB outputs unchanged and perform no memory write.
REQ-017 SHALL drive ResultW combinationally: ResultSrcW 00 -> ALUResultW, 01 -> ReadDataW, 10 -> PCPlus4W, 11 -> ALUResultW.
REQ-018 SHALL treat MemWriteM and RegWriteM independently; both high performs store and register write.

Reset
REQ-019 SHALL, while reset=0, asynchronously clear ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, MisalignW to 0; ResultW thus 0.
REQ-020 SHALL NOT reset memory contents; a store coincident with reset assertion SHALL be dropped.
REQ-021 SHALL resume normal capture on first rising clk after reset deasserts.

Configuration
REQ-022 SHALL, with DMEM_MISALIGN_CHECK_EN defined, flag access misaligned when ALUResultM[1:0]!=0 and (MemWriteM=1 or ResultSrcM=01); store suppressed, RegWriteW captured as 0, MisalignW captured as 1.
REQ-023 SHALL, without DMEM_MISALIGN_CHECK_EN, ignore ALUResultM[1:0] and tie MisalignW to 0.

Structure
REQ-024 SHALL place XLEN=32 and result-select enum (RESULT_ALU=00, RESULT_MEM=01, RESULT_PC4=10) in shared package riscv_pkg.
REQ-025 SHALL implement storage as sub-module dmem (DEPTH parameter, sync write, async read); MEM/WB register and mux stay in memory_stage.

Verification
REQ-026 SHALL cover: store 0xDEADBEEF to 0x10, next cycle load 0x10 with ResultSrcM=01 -> ReadDataW=ResultW=0xDEADBEEF one cycle later.
REQ-027 SHALL cover: simultaneous store 0x11111111 and load at 0x20 holding 0x22222222 -> ReadDataW=0x22222222, next load returns 0x11111111.
REQ-028 SHALL cover: StallW=1 for 2 cycles with MemWriteM=1 to 0x30 (prior 0) -> W outputs frozen, later load of 0x30 returns 0.
REQ-029 SHALL cover: DEPTH=64, store 0x5A to 0x100 -> load from 0x000 returns 0x5A (wrap).
REQ-030 SHALL cover: reset=0 asserted mid-stream between edges -> all W outputs 0 immediately, memory contents preserved.
REQ-031 SHALL cover, with DMEM_MISALIGN_CHECK_EN: store to 0x13 -> MisalignW=1, RegWriteW=0, word 0x10 unchanged; without macro, same store writes word 0x10.
